fetch_pair: RTL and testbench

Dual-issue fetch stage that sits directly upstream of the instruction steer stage. It owns the program counter and drives a synchronous instruction memory. Each cycle it presents a pair of consecutive instructions plus the pair's base address and a free-running cycle counter, which the steer stage combines into instruction IDs. It honours the steer stage's re-present request (`steer_stall`), the global pipeline `stall`, and taken-branch redirects (`flush`).

---
 rtl/fetch_pair_pkg.sv | 21 ++
 rtl/fetch_pair_cycle_counter.sv | 27 ++
 rtl/fetch_pair.sv | 94 +++++++++
 tb/tb_fetch_pair.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pair_pkg.sv
// Shared definitions for the dual-issue fetch stage.
//   ADDR_WIDTH            - instruction address width (word addresses)
//   INST_WIDTH            - instruction word width
//   INSTRUCTION_ID_WIDTH  - width of the free-running ID base counter
//   NOP_INSTRUCTION       - encoding presented for bubbles and killed pairs
//   fetch_state_e         - fetch_valid FSM: WARMUP (bubble) / RUN (real pairs)
package fetch_pair_pkg;

    localparam int ADDR_WIDTH           = 8;
    localparam int INST_WIDTH           = 32;
    localparam int INSTRUCTION_ID_WIDTH = 4;

    localparam logic [INST_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0013;

    // The encoding doubles as the fetch_valid output bit.
    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_pair_cycle_counter.sv
// Free-running instruction-ID base counter.
//   clk    - clock, rising edge
//   reset  - asynchronous active-high clear
//   enable - advance by one on this edge
//   count  - current value, wraps at 2^WIDTH
module cycle_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fetch_pair.sv
// Dual-issue fetch stage. Owns the PC, drives a synchronous instruction
// memory with the base address of the next pair and presents the pair that
// memory returns, together with its base address and an ID-base counter.
//   clk, reset                         - clock / async active-high reset
//   stall                              - global stall: hold presented pair
//   steer_stall                        - steer asks for the same pair again
//   flush, branch_address              - taken-branch redirect
//   imem_addr                          - pair base address to memory
//   imem_data0, imem_data1             - memory data for base and base+1
//   instruction0_out, instruction1_out - pair to steer (NOP when bubble)
//   pc_out                             - address of instruction0_out
//   cycle_count                        - instruction-ID base
//   fetch_valid                        - presented pair is real
module fetch_pair
    import fetch_pair_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            stall,
    input  logic                            steer_stall,
    input  logic                            flush,
    input  logic [ADDR_WIDTH-1:0]           branch_address,
    output logic [ADDR_WIDTH-1:0]           imem_addr,
    input  logic [INST_WIDTH-1:0]           imem_data0,
    input  logic [INST_WIDTH-1:0]           imem_data1,
    output logic [INST_WIDTH-1:0]           instruction0_out,
    output logic [INST_WIDTH-1:0]           instruction1_out,
    output logic [ADDR_WIDTH-1:0]           pc_out,
    output logic [INSTRUCTION_ID_WIDTH-1:0] cycle_count,
    output logic                            fetch_valid
);

    fetch_state_e          state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic                  kill_pair;
    logic [INST_WIDTH-1:0] mem_lane [2];
    logic [INST_WIDTH-1:0] out_lane [2];

    // State register; pc_reg reloads every edge so a hold re-reads memory
    // at the same address and the returned data stays stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= WARMUP;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // Next-state / next-PC. Flush beats every hold condition; during WARMUP
    // the PC holds so the first real pair is the one at RESET_PC.
    always_comb begin
        state_next = RUN;
        pc_next    = pc_reg + ADDR_WIDTH'(2);
        if (flush) begin
            pc_next = branch_address;
        end else if ((state_reg == WARMUP) || stall || steer_stall) begin
            pc_next = pc_reg;
        end
    end

    assign imem_addr   = pc_next;
    assign pc_out      = pc_reg;
    assign fetch_valid = (state_reg == RUN);

    // A flushed pair is on the wrong path; it is replaced only in the flush
    // cycle, the FSM itself stays in RUN.
    assign kill_pair   = !fetch_valid || flush;
    assign mem_lane[0] = imem_data0;
    assign mem_lane[1] = imem_data1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign out_lane[gi] = kill_pair ? NOP_INSTRUCTION : mem_lane[gi];
        end
    endgenerate

    assign instruction0_out = out_lane[0];
    assign instruction1_out = out_lane[1];

    // Counts steer_stall cycles too, so the halves of a split pair differ.
    cycle_counter #(
        .WIDTH (INSTRUCTION_ID_WIDTH)
    ) u_cycle_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (!stall),
        .count  (cycle_count)
    );

endmodule

// File: tb/tb_fetch_pair.sv
module tb_fetch_pair;
    import fetch_pair_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] RST_PC = 8'h10;
    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
    localparam int ID_MOD    = 1 << INSTRUCTION_ID_WIDTH;

    logic                            clk = 1'b0;
    logic                            reset;
    logic                            stall, steer_stall, flush;
    logic [ADDR_WIDTH-1:0]           branch_address;
    logic [ADDR_WIDTH-1:0]           imem_addr;
    logic [INST_WIDTH-1:0]           imem_data0, imem_data1;
    logic [INST_WIDTH-1:0]           instruction0_out, instruction1_out;
    logic [ADDR_WIDTH-1:0]           pc_out;
    logic [INSTRUCTION_ID_WIDTH-1:0] cycle_count;
    logic                            fetch_valid;

    fetch_pair #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .steer_stall      (steer_stall),
        .flush            (flush),
        .branch_address   (branch_address),
        .imem_addr        (imem_addr),
        .imem_data0       (imem_data0),
        .imem_data1       (imem_data1),
        .instruction0_out (instruction0_out),
        .instruction1_out (instruction1_out),
        .pc_out           (pc_out),
        .cycle_count      (cycle_count),
        .fetch_valid      (fetch_valid)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data for addr and addr+1 one cycle later.
    logic [INST_WIDTH-1:0] mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_p1;
    assign addr_p1 = imem_addr + 8'd1;
    always @(posedge clk) begin
        imem_data0 <= mem[imem_addr];
        imem_data1 <= mem[addr_p1];
    end

    // Reference model: the presented pair is simply the memory words at the
    // presented PC; pc/cnt advance by architectural rules.
    int m_pc;     // 0..MEM_DEPTH-1
    int m_cnt;    // 0..ID_MOD-1
    bit m_valid;
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = int'(RST_PC);
        m_cnt   = 0;
        m_valid = 0;
    endtask

    // Called at a negedge: apply inputs, check, advance one edge, return at negedge.
    task automatic cycle(input bit s, input bit ss, input bit f, input int ba);
        int exp_addr;
        logic [INST_WIDTH-1:0] e0, e1;
        stall          = s;
        steer_stall    = ss;
        flush          = f;
        branch_address = ADDR_WIDTH'(ba);
        #1;
        if (f)                      exp_addr = ba % MEM_DEPTH;
        else if (!m_valid || s || ss) exp_addr = m_pc;
        else                        exp_addr = (m_pc + 2) % MEM_DEPTH;
        e0 = (!m_valid || f) ? NOP_INSTRUCTION : mem[m_pc];
        e1 = (!m_valid || f) ? NOP_INSTRUCTION : mem[(m_pc + 1) % MEM_DEPTH];
        vectors++;
        $display("cyc %0d s=%0b ss=%0b f=%0b ba=%02h | pc=%02h addr=%02h id=%0d v=%0b i0=%08h i1=%08h",
                 vectors, s, ss, f, ba[7:0], pc_out, imem_addr, cycle_count, fetch_valid,
                 instruction0_out, instruction1_out);
        chk("imem_addr",   64'(imem_addr),        64'(exp_addr));
        chk("pc_out",      64'(pc_out),           64'(m_pc));
        chk("cycle_count", 64'(cycle_count),      64'(m_cnt));
        chk("fetch_valid", 64'(fetch_valid),      64'(m_valid));
        chk("instr0",      64'(instruction0_out), 64'(e0));
        chk("instr1",      64'(instruction1_out), 64'(e1));
        @(posedge clk);
        m_pc    = exp_addr;
        m_valid = 1;
        if (!s) m_cnt = (m_cnt + 1) % ID_MOD;
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        #1;
        vectors++;
        $display("reset check %s: pc=%02h addr=%02h id=%0d v=%0b", tag, pc_out, imem_addr,
                 cycle_count, fetch_valid);
        chk({tag, "_pc"},    64'(pc_out),           64'(RST_PC));
        chk({tag, "_addr"},  64'(imem_addr),        64'(RST_PC));
        chk({tag, "_cnt"},   64'(cycle_count),      64'(0));
        chk({tag, "_valid"}, 64'(fetch_valid),      64'(0));
        chk({tag, "_i0"},    64'(instruction0_out), 64'(NOP_INSTRUCTION));
        chk({tag, "_i1"},    64'(instruction1_out), 64'(NOP_INSTRUCTION));
    endtask

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
        reset = 1; stall = 0; steer_stall = 0; flush = 0; branch_address = '0;
        model_reset();
        @(negedge clk);
        check_reset_state("por");
        @(posedge clk);
        @(negedge clk);
        reset = 0;

        // Warmup then sequential: 0x10 (warmup), 0x10, 0x12, 0x14
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // steer_stall at 0x14: re-present, counter still advances
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        // global stall for 3 cycles then resume
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // stall + steer_stall holds
        cycle(1, 1, 0, 0);
        // flush to odd address while stalled
        cycle(1, 0, 1, 'h41);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // flush with steer_stall; then wrap at the top of the address space
        cycle(0, 1, 1, 'hFE);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // odd address at the very top: pair wraps (0xFF, 0x00)
        cycle(0, 0, 1, 'hFF);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(3) == 0), ($urandom_range(3) == 0),
                  ($urandom_range(7) == 0), int'($urandom_range(MEM_DEPTH - 1)));
        end

        // Asynchronous reset mid-run, checked before any clock edge
        stall = 0; steer_stall = 0; flush = 0;
        reset = 1;
        model_reset();
        check_reset_state("mid");
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        for (int n = 0; n < 4; n++) cycle(0, 0, 0, 0);
        for (int n = 0; n < 40; n++) begin
            cycle(($urandom_range(3) == 0), ($urandom_range(3) == 0),
                  ($urandom_range(7) == 0), int'($urandom_range(MEM_DEPTH - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
